muldiv_arbiter: RTL and testbench

Shares one iterative RV32M multiply/divide unit between `NUM_REQ` requesters, such as two issue ports or two harts. The block does round-robin arbitration and captures operands and the destination tag. It sequences a single-issue handshake to the unit and routes the result back to the winning requester. Division corner cases (divide by zero, signed overflow) are resolved locally without engaging the unit.

---
 rtl/muldiv_arb_pkg.sv | 36 +++
 rtl/muldiv_arbiter_if.sv | 44 ++++
 rtl/muldiv_arbiter_rr_arbiter.sv | 41 ++++
 rtl/muldiv_arbiter.sv | 150 +++++++++++++++
 tb/tb_muldiv_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_arb_pkg.sv
// =====================================================================
// muldiv_arb_pkg : shared types and constants for the mul/div arbiter
// Rev 1.0
// =====================================================================
`default_nettype none

package muldiv_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;

   // funct3[2] separates the divide family from the multiply family
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_arbiter_if.sv
// =====================================================================
// muldiv_arbiter_if : requester, response and unit-side bundle
// Rev 1.0
// =====================================================================
`default_nettype none

interface muldiv_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32
);
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic [NUM_REQ*3-1:0]    req_op_i;
   logic [NUM_REQ*XLEN-1:0] req_ra_i;
   logic [NUM_REQ*XLEN-1:0] req_rb_i;
   logic [NUM_REQ*5-1:0]    req_rd_i;
   logic                    flush_i;
   logic [NUM_REQ-1:0]      rsp_valid_o;
   logic [XLEN-1:0]         rsp_result_o;
   logic [4:0]              rsp_rd_o;
   logic                    md_valid_o;
   logic [2:0]              md_op_o;
   logic [XLEN-1:0]         md_ra_o;
   logic [XLEN-1:0]         md_rb_o;
   logic                    md_ready_i;
   logic [XLEN-1:0]         md_result_i;
   logic                    busy_o;

   modport master (
      input  req_valid_i, req_op_i, req_ra_i, req_rb_i, req_rd_i, flush_i,
             md_ready_i, md_result_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_rd_o,
             md_valid_o, md_op_o, md_ra_o, md_rb_o, busy_o
   );

   modport slave (
      output req_valid_i, req_op_i, req_ra_i, req_rb_i, req_rd_i, flush_i,
             md_ready_i, md_result_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_rd_o,
             md_valid_o, md_op_o, md_ra_o, md_rb_o, busy_o
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_arbiter_rr_arbiter.sv
// =====================================================================
// rr_arbiter : one-hot grant to the first request at or after ptr
// Rev 1.0
// =====================================================================
`default_nettype none

module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // one extra bit holds ptr+i before the wrap back into range
         sum = {1'b0, ptr} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_arbiter.sv
// =====================================================================
// muldiv_arbiter : round-robin sharing of one iterative RV32M unit
// Rev 1.0
// =====================================================================
`default_nettype none

module muldiv_arbiter #(
   parameter  int NUM_REQ = 2,
   parameter  int XLEN    = 32,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   muldiv_arbiter_if.master  bus
);
   import muldiv_arb_pkg::*;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   state_e             state, state_nxt;
   logic [PTR_W-1:0]   rr_ptr, owner, sel_owner;
   logic [2:0]         op_q, sel_op;
   logic [XLEN-1:0]    ra_q, rb_q, result_q, sel_ra, sel_rb, corner_val;
   logic [4:0]         rd_q, sel_rd;
   logic [NUM_REQ-1:0] req_masked, grant;
   logic               handshake, corner_hit, rsp_fire;

   // grants only exist in IDLE and are withheld for a cycle on flush
   assign req_masked = (state == ST_IDLE && !bus.flush_i) ? bus.req_valid_i : '0;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req   (req_masked),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   assign handshake = |grant;

   always_comb begin
      sel_owner = '0;
      sel_op    = '0;
      sel_ra    = '0;
      sel_rb    = '0;
      sel_rd    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_owner = PTR_W'(i);
            sel_op    = bus.req_op_i[i*3 +: 3];
            sel_ra    = bus.req_ra_i[i*XLEN +: XLEN];
            sel_rb    = bus.req_rb_i[i*XLEN +: XLEN];
            sel_rd    = bus.req_rd_i[i*5 +: 5];
         end
      end
   end

   // divide corner cases resolved here so the unit never sees them
   always_comb begin
      corner_hit = 1'b0;
      corner_val = '0;
      if (is_div(sel_op)) begin
         if (sel_rb == '0) begin
            corner_hit = 1'b1;
            corner_val = sel_op[1] ? sel_ra : ALL_ONES;
         end else if (!sel_op[0] && sel_ra == MIN_NEG && sel_rb == ALL_ONES) begin
            corner_hit = 1'b1;
            corner_val = sel_op[1] ? '0 : MIN_NEG;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rsp_fire  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (handshake) begin
               state_nxt = corner_hit ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = bus.flush_i ? ST_DRAIN : ST_WAIT;
         ST_WAIT: begin
            if (bus.flush_i) begin
               state_nxt = bus.md_ready_i ? ST_IDLE : ST_DRAIN;
            end else if (bus.md_ready_i) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_fire  = !bus.flush_i;
            state_nxt = ST_IDLE;
         end
         ST_DRAIN: begin
            if (bus.md_ready_i) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr   <= '0;
         owner    <= '0;
         op_q     <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         if (state == ST_IDLE && handshake) begin
            owner    <= sel_owner;
            op_q     <= sel_op;
            ra_q     <= sel_ra;
            rb_q     <= sel_rb;
            rd_q     <= sel_rd;
            result_q <= corner_val;
         end
         if (state == ST_WAIT && bus.md_ready_i && !bus.flush_i) begin
            result_q <= bus.md_result_i;
         end
         // every return to IDLE, served or abandoned, moves past the owner
         if (state != ST_IDLE && state_nxt == ST_IDLE) begin
            rr_ptr <= (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + PTR_W'(1);
         end
      end
   end

   assign bus.req_ready_o  = grant;
   assign bus.busy_o       = (state != ST_IDLE);
   assign bus.md_valid_o   = (state == ST_ISSUE);
   assign bus.md_op_o      = (state == ST_ISSUE) ? op_q : '0;
   assign bus.md_ra_o      = (state == ST_ISSUE) ? ra_q : '0;
   assign bus.md_rb_o      = (state == ST_ISSUE) ? rb_q : '0;
   assign bus.rsp_valid_o  = rsp_fire ? (NUM_REQ'(1) << owner) : '0;
   assign bus.rsp_result_o = (rsp_fire && rd_q != 5'd0) ? result_q : '0;
   assign bus.rsp_rd_o     = rsp_fire ? rd_q : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_arbiter.sv
// =====================================================================
// tb_muldiv_arbiter : directed and randomized checks against an RV32M model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_muldiv_arbiter;
   import muldiv_arb_pkg::*;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   mptr     = 0;

   bit          pv  [2];
   logic [2:0]  pop [2];
   logic [31:0] pa  [2];
   logic [31:0] pb  [2];
   logic [4:0]  prd [2];

   always #5 clk = ~clk;

   muldiv_arbiter_if #(.NUM_REQ(2), .XLEN(32)) bus ();

   muldiv_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      case (op)
         OP_MUL:    return a * b;
         OP_MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
         OP_MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});       return sp[63:32]; end
         OP_MULHU:  begin up = {32'd0, a} * {32'd0, b};                                return up[63:32]; end
         OP_DIV:    if (b == 0) return ALL1;
                    else if (a == INT_MIN && b == ALL1) return INT_MIN;
                    else return $signed(a) / $signed(b);
         OP_DIVU:   return (b == 0) ? ALL1 : a / b;
         OP_REM:    if (b == 0) return a;
                    else if (a == INT_MIN && b == ALL1) return 32'd0;
                    else return $signed(a) % $signed(b);
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      bus.req_op_i[r*3 +: 3]   = op;
      bus.req_ra_i[r*32 +: 32] = a;
      bus.req_rb_i[r*32 +: 32] = b;
      bus.req_rd_i[r*5 +: 5]   = rd;
      bus.req_valid_i[r]       = 1'b1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
      chk({tag, "_rsp_result"}, bus.rsp_result_o, 0);
      chk({tag, "_md_valid"}, bus.md_valid_o, 0);
   endtask

   // Called in the handshake cycle with requests settled; returns one cycle after the response.
   task automatic complete(input int r, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input int lat);
      bit          corner;
      logic [31:0] exp_res;
      corner  = op[2] && (b == 0 || (!op[0] && a == INT_MIN && b == ALL1));
      exp_res = (rd == 0) ? 32'd0 : ref_md(op, a, b);
      chk("hs_ready", bus.req_ready_o, 1 << r);
      tick();
      bus.req_valid_i[r] = 1'b0;
      #1;
      chk("c1_ready", bus.req_ready_o, 0);
      if (corner) begin
         chk("fast_md_valid", bus.md_valid_o, 0);
         chk("fast_rsp_valid", bus.rsp_valid_o, 1 << r);
         chk("fast_result", bus.rsp_result_o, exp_res);
         chk("fast_rd", bus.rsp_rd_o, rd);
      end else begin
         chk("issue_md_valid", bus.md_valid_o, 1);
         chk("issue_md_op", bus.md_op_o, op);
         chk("issue_md_ra", bus.md_ra_o, a);
         chk("issue_md_rb", bus.md_rb_o, b);
         chk("issue_rsp_valid", bus.rsp_valid_o, 0);
         for (int c = 0; c < lat - 1; c++) begin
            tick();
            chk("wait_md_valid", bus.md_valid_o, 0);
            chk("wait_rsp_valid", bus.rsp_valid_o, 0);
         end
         tick();
         bus.md_ready_i  = 1'b1;
         bus.md_result_i = ref_md(op, a, b);
         #1;
         chk("ready_rsp_valid", bus.rsp_valid_o, 0);
         tick();
         bus.md_ready_i  = 1'b0;
         bus.md_result_i = $urandom;
         #1;
         chk("rsp_valid", bus.rsp_valid_o, 1 << r);
         chk("rsp_result", bus.rsp_result_o, exp_res);
         chk("rsp_rd", bus.rsp_rd_o, rd);
      end
      tick();
      chk("after_busy", bus.busy_o, 0);
      chk("after_rsp_valid", bus.rsp_valid_o, 0);
      mptr = (r + 1) % 2;
   endtask

   task automatic issue_to_c1(input int r, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
      drive(r, op, a, b, rd);
      #1;
      chk("fl_ready", bus.req_ready_o, 1 << r);
      tick();
      bus.req_valid_i[r] = 1'b0;
      #1;
      chk("fl_md_valid", bus.md_valid_o, 1);
   endtask

   task automatic gen(input int q);
      int s;
      s      = $urandom_range(0, 7);
      pop[q] = 3'($urandom_range(0, 7));
      pa[q]  = $urandom;
      pb[q]  = $urandom;
      if (s == 0) pb[q] = 32'd0;
      else if (s == 1) begin pa[q] = INT_MIN; pb[q] = ALL1; end
      prd[q] = (s == 2) ? 5'd0 : 5'($urandom_range(0, 31));
      pv[q]  = 1'b1;
      drive(q, pop[q], pa[q], pb[q], prd[q]);
   endtask

   initial begin
      int w;
      bus.req_valid_i = '0;
      bus.req_op_i    = '0;
      bus.req_ra_i    = '0;
      bus.req_rb_i    = '0;
      bus.req_rd_i    = '0;
      bus.flush_i     = 1'b0;
      bus.md_ready_i  = 1'b0;
      bus.md_result_i = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_quiet("rst");
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_md_op", bus.md_op_o, 0);
      chk("rst_rd", bus.rsp_rd_o, 0);
      resetn = 1'b1;
      tick();

      // Both requesters valid from reset: requester 0 first, then 1
      drive(0, OP_DIVU, 32'd100, 32'd7, 5'd3);
      drive(1, OP_DIVU, 32'd100, 32'd7, 5'd4);
      #1;
      complete(0, OP_DIVU, 32'd100, 32'd7, 5'd3, 2);
      complete(1, OP_DIVU, 32'd100, 32'd7, 5'd4, 1);

      // MUL 7*6 with the unit answering at cycle 4
      drive(0, OP_MUL, 32'd7, 32'd6, 5'd5);
      #1;
      complete(0, OP_MUL, 32'd7, 32'd6, 5'd5, 3);

      // Corner paths: signed overflow and remainder by zero
      drive(1, OP_DIV, INT_MIN, ALL1, 5'd7);
      #1;
      complete(1, OP_DIV, INT_MIN, ALL1, 5'd7, 1);
      drive(0, OP_REMU, 32'd9, 32'd0, 5'd8);
      #1;
      complete(0, OP_REMU, 32'd9, 32'd0, 5'd8, 1);

      // Flush in WAIT, unit answers two cycles later
      issue_to_c1(0, OP_MUL, 32'd3, 32'd4, 5'd6);
      tick();
      bus.flush_i = 1'b1;
      #1;
      chk("flw_rsp", bus.rsp_valid_o, 0);
      tick();
      bus.flush_i = 1'b0;
      #1;
      chk("drain_busy", bus.busy_o, 1);
      chk_quiet("drain");
      tick();
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'd12;
      #1;
      chk("drain_ready_rsp", bus.rsp_valid_o, 0);
      tick();
      bus.md_ready_i = 1'b0;
      #1;
      chk("flw_done_busy", bus.busy_o, 0);
      chk("flw_done_rsp", bus.rsp_valid_o, 0);
      mptr = 1;
      drive(0, OP_MUL, 32'd11, 32'd13, 5'd9);
      drive(1, OP_MULHU, 32'hFFFF_0000, 32'h0001_0003, 5'd10);
      #1;
      complete(1, OP_MULHU, 32'hFFFF_0000, 32'h0001_0003, 5'd10, 2);
      complete(0, OP_MUL, 32'd11, 32'd13, 5'd9, 1);

      // Flush in WAIT with the unit answering the same cycle
      issue_to_c1(1, OP_DIVU, 32'd50, 32'd5, 5'd2);
      tick();
      bus.flush_i     = 1'b1;
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'd10;
      #1;
      chk("flr_rsp", bus.rsp_valid_o, 0);
      tick();
      bus.flush_i    = 1'b0;
      bus.md_ready_i = 1'b0;
      #1;
      chk("flr_busy", bus.busy_o, 0);
      chk("flr_rsp2", bus.rsp_valid_o, 0);

      // Flush in ISSUE: strobe still sent, then DRAIN
      issue_to_c1(0, OP_MULH, 32'd5, 32'd6, 5'd2);
      bus.flush_i = 1'b1;
      #1;
      chk("fli_md_valid", bus.md_valid_o, 1);
      tick();
      bus.flush_i = 1'b0;
      #1;
      chk("fli_busy", bus.busy_o, 1);
      chk("fli_md_valid2", bus.md_valid_o, 0);
      tick();
      bus.md_ready_i = 1'b1;
      #1;
      tick();
      bus.md_ready_i = 1'b0;
      #1;
      chk("fli_done_busy", bus.busy_o, 0);
      chk("fli_done_rsp", bus.rsp_valid_o, 0);

      // Flush in RESP suppresses the response
      drive(1, OP_DIVU, 32'd77, 32'd0, 5'd2);
      #1;
      chk("flp_ready", bus.req_ready_o, 2);
      tick();
      bus.req_valid_i[1] = 1'b0;
      bus.flush_i        = 1'b1;
      #1;
      chk("flp_rsp", bus.rsp_valid_o, 0);
      chk("flp_busy", bus.busy_o, 1);
      tick();
      bus.flush_i = 1'b0;
      #1;
      chk("flp_done_busy", bus.busy_o, 0);

      // Flush in IDLE blocks the grant for that cycle
      drive(0, OP_MUL, 32'd5, 32'd5, 5'd1);
      bus.flush_i = 1'b1;
      #1;
      chk("fl_idle_ready", bus.req_ready_o, 0);
      tick();
      bus.flush_i = 1'b0;
      #1;
      complete(0, OP_MUL, 32'd5, 32'd5, 5'd1, 2);

      // Reset in WAIT: outputs clear, pointer returns to 0, late ready ignored
      issue_to_c1(1, OP_MUL, 32'd9, 32'd9, 5'd4);
      tick();
      chk("rw_busy", bus.busy_o, 1);
      resetn = 1'b0;
      #1;
      chk_quiet("rw");
      chk("rw_busy0", bus.busy_o, 0);
      chk("rw_md_ra", bus.md_ra_o, 0);
      chk("rw_ready", bus.req_ready_o, 0);
      tick();
      resetn = 1'b1;
      #1;
      tick();
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'd81;
      #1;
      chk("late_rsp", bus.rsp_valid_o, 0);
      tick();
      bus.md_ready_i = 1'b0;
      #1;
      chk("late_rsp2", bus.rsp_valid_o, 0);
      chk("late_busy", bus.busy_o, 0);
      mptr = 0;
      drive(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
      drive(1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      #1;
      complete(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 1);
      complete(1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 3);

      // Randomized traffic with a round-robin pointer kept by the bench
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      for (int it = 0; it < 40; it++) begin
         for (int q = 0; q < 2; q++) begin
            if (!pv[q] && $urandom_range(0, 2) != 0) gen(q);
         end
         if (!pv[0] && !pv[1]) gen(int'($urandom_range(0, 1)));
         #1;
         w = pv[mptr] ? mptr : 1 - mptr;
         complete(w, pop[w], pa[w], pb[w], prd[w], int'($urandom_range(1, 5)));
         pv[w] = 1'b0;
      end
      for (int q = 0; q < 2; q++) begin
         if (pv[q]) begin
            #1;
            complete(q, pop[q], pa[q], pb[q], prd[q], 1);
            pv[q] = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
